// File: rtl/pmu_ahb_lite.sv
// pmu_ahb_lite: AHB-Lite slave performance monitoring unit with per-counter event selection,
// overflow interrupt and an optional quota interrupt built when `PMU_QUOTA_EN is defined.
`timescale 1ns/1ps
module pmu_ahb_lite #(
    parameter logic [31:0] haddr              = 32'h80100000,
    parameter logic [31:0] hmask              = 32'hfff,
    parameter int          REG_WIDTH          = 32,
    parameter int          N_COUNTERS         = 24,
    parameter int          N_SOC_EV           = 128,
    parameter int          MCCU_N_CORES       = 6,
    parameter int          N_CONF_REGS        = 1,
    parameter int          MCCU_WEIGHTS_WIDTH = 8,
    parameter int          MCCU_N_EVENTS      = 2,
    parameter int          FT                 = 0
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  hsel_i,
    input  logic                  hreadyi_i,
    input  logic [31:0]           haddr_i,
    input  logic                  hwrite_i,
    input  logic [1:0]            htrans_i,
    input  logic [2:0]            hsize_i,
    input  logic [2:0]            hburst_i,
    input  logic [3:0]            hprot_i,
    input  logic                  hmastlock_i,
    input  logic [REG_WIDTH-1:0]  hwdata_i,
    output logic                  hreadyo_o,
    output logic [1:0]            hresp_o,
    output logic [REG_WIDTH-1:0]  hrdata_o,
    input  logic [N_SOC_EV-1:0]   events_i,
    output logic                  intr_overflow_o,
    output logic                  intr_quota_o,
    output logic                  intr_MCCU_o,
    output logic                  intr_RDC_o,
    output logic                  intr_FT1_o,
    output logic                  intr_FT2_o
);

    // Word-index register map, derived from the counter count.
    localparam int OFS_W       = $clog2(hmask + 32'd1);
    localparam int IDX_W       = OFS_W - 2;
    localparam int IDX_MAIN    = 0;
    localparam int IDX_CNT0    = 1;
    localparam int IDX_OVF_IEN = N_COUNTERS + 1;
    localparam int IDX_OVF_STS = N_COUNTERS + 2;
    localparam int IDX_SEL0    = N_COUNTERS + 3;
    localparam int N_SEL_WORDS = (N_COUNTERS + 3) / 4;
`ifdef PMU_QUOTA_EN
    localparam int IDX_QMASK   = IDX_SEL0 + N_SEL_WORDS;
    localparam int IDX_QLIMIT  = IDX_QMASK + 1;
    localparam int QUOTA_W     = REG_WIDTH + $clog2(N_COUNTERS + 1);
`endif

    localparam int unused_params = MCCU_N_CORES + N_CONF_REGS + MCCU_WEIGHTS_WIDTH
                                 + MCCU_N_EVENTS + FT;
    logic unused_inputs;
    assign unused_inputs = ^{hsize_i, hburst_i, hprot_i, hmastlock_i, htrans_i[0], haddr_i[1:0]};

    // ------------------------------------------------------------------ bus pipeline
    logic             addr_hit;
    logic             dp_valid;
    logic             dp_write;
    logic [IDX_W-1:0] dp_idx;
    int               dp_word;
    logic             wr_en;
    logic             rd_en;

    assign addr_hit = hsel_i && hreadyi_i && htrans_i[1]
                   && ((haddr_i & ~hmask) == (haddr & ~hmask));

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_idx   <= '0;
        end else begin
            dp_valid <= addr_hit;
            dp_write <= hwrite_i;
            dp_idx   <= haddr_i[OFS_W-1:2];
        end
    end

    assign dp_word = int'(dp_idx);
    assign wr_en   = dp_valid && dp_write;
    assign rd_en   = dp_valid && !dp_write;

    assign hreadyo_o   = 1'b1;
    assign hresp_o     = 2'b00;
    assign intr_MCCU_o = 1'b0;
    assign intr_RDC_o  = 1'b0;
    assign intr_FT1_o  = 1'b0;
    assign intr_FT2_o  = 1'b0;

    // ------------------------------------------------------------------ write decode
    logic                   wr_main;
    logic                   wr_ien;
    logic                   wr_sts;
    logic [N_COUNTERS-1:0]  wr_cnt;
    logic [N_SEL_WORDS-1:0] wr_sel;
    logic                   soft_rst;
`ifdef PMU_QUOTA_EN
    logic                   wr_qmask;
    logic                   wr_qlimit;
`endif

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        wr_main = 1'b0;
        wr_ien  = 1'b0;
        wr_sts  = 1'b0;
        wr_cnt  = '0;
        wr_sel  = '0;
`ifdef PMU_QUOTA_EN
        wr_qmask  = 1'b0;
        wr_qlimit = 1'b0;
`endif
        if (wr_en) begin
            wr_main = (dp_word == IDX_MAIN);
            wr_ien  = (dp_word == IDX_OVF_IEN);
            wr_sts  = (dp_word == IDX_OVF_STS);
            for (int i = 0; i < N_COUNTERS; i++)
                wr_cnt[i] = (dp_word == IDX_CNT0 + i);
            for (int w = 0; w < N_SEL_WORDS; w++)
                wr_sel[w] = (dp_word == IDX_SEL0 + w);
`ifdef PMU_QUOTA_EN
            wr_qmask  = (dp_word == IDX_QMASK);
            wr_qlimit = (dp_word == IDX_QLIMIT);
`endif
        end
    end

    // Softreset is a pulse on the write itself; nothing is stored, so it always reads 0.
    assign soft_rst = wr_main && hwdata_i[1];

    // ------------------------------------------------------------------ configuration
    logic                  enable;
    logic [7:0]            ev_sel [N_COUNTERS];
    logic [N_COUNTERS-1:0] ovf_ien;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            enable  <= 1'b0;
            ovf_ien <= '0;
        end else begin
            if (wr_main) enable  <= hwdata_i[0];
            if (wr_ien)  ovf_ien <= hwdata_i[N_COUNTERS-1:0];
        end
    end

    // NOTE: register arrays are reset element by element; every architectural register reads 0 after reset.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < N_COUNTERS; i++) ev_sel[i] <= '0;
        end else begin
            for (int i = 0; i < N_COUNTERS; i++)
                if (wr_sel[i/4]) ev_sel[i] <= hwdata_i[8*(i%4) +: 8];
        end
    end

    // ------------------------------------------------------------------ counters
    logic [255:0]          ev_ext;
    logic [N_COUNTERS-1:0] ev_hit;
    logic [N_COUNTERS-1:0] ovf_set;
    logic [REG_WIDTH-1:0]  cnt [N_COUNTERS];

    // Zero-extension makes selector values beyond the last event read a constant 0.
    assign ev_ext = 256'(events_i);

    always_comb begin
        ev_hit  = '0;
        ovf_set = '0;
        for (int i = 0; i < N_COUNTERS; i++) begin
            ev_hit[i]  = ev_ext[ev_sel[i]];
            ovf_set[i] = enable && ev_hit[i] && !wr_cnt[i] && (&cnt[i]);
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < N_COUNTERS; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_COUNTERS; i++) begin
                if (soft_rst)
                    cnt[i] <= '0;
                else if (wr_cnt[i])
                    cnt[i] <= hwdata_i;
                else if (enable && ev_hit[i])
                    cnt[i] <= cnt[i] + REG_WIDTH'(1);
            end
        end
    end

    // ------------------------------------------------------------------ overflow
    logic [N_COUNTERS-1:0] ovf_sts;
    logic [N_COUNTERS-1:0] w1c_mask;
    logic                  intr_ovf_q;

    assign w1c_mask = wr_sts ? hwdata_i[N_COUNTERS-1:0] : '0;

    // A hardware set in the same cycle as a clear of that bit keeps the bit set.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ovf_sts    <= '0;
            intr_ovf_q <= 1'b0;
        end else begin
            if (soft_rst) ovf_sts <= '0;
            else          ovf_sts <= (ovf_sts & ~w1c_mask) | ovf_set;
            intr_ovf_q <= |(ovf_sts & ovf_ien);
        end
    end

    assign intr_overflow_o = intr_ovf_q;

    // ------------------------------------------------------------------ quota
`ifdef PMU_QUOTA_EN
    logic [N_COUNTERS-1:0] quota_mask;
    logic [REG_WIDTH-1:0]  quota_limit;
    logic [QUOTA_W-1:0]    quota_sum;
    logic                  intr_quota_q;

    // NOTE: blocking accumulation is correct here because this block is purely combinational.
    always_comb begin
        quota_sum = '0;
        for (int i = 0; i < N_COUNTERS; i++)
            if (quota_mask[i]) quota_sum = quota_sum + QUOTA_W'(cnt[i]);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            quota_mask   <= '0;
            quota_limit  <= '0;
            intr_quota_q <= 1'b0;
        end else begin
            if (wr_qmask)  quota_mask  <= hwdata_i[N_COUNTERS-1:0];
            if (wr_qlimit) quota_limit <= hwdata_i;
            intr_quota_q <= (quota_sum > QUOTA_W'(quota_limit));
        end
    end

    assign intr_quota_o = intr_quota_q;
`else
    assign intr_quota_o = 1'b0;
`endif

    // ------------------------------------------------------------------ read data
    logic [REG_WIDTH-1:0] rd_data;

    always_comb begin
        rd_data = '0;
        if (rd_en) begin
            if (dp_word == IDX_MAIN)    rd_data = REG_WIDTH'(enable);
            if (dp_word == IDX_OVF_IEN) rd_data = REG_WIDTH'(ovf_ien);
            if (dp_word == IDX_OVF_STS) rd_data = REG_WIDTH'(ovf_sts);
            for (int i = 0; i < N_COUNTERS; i++)
                if (dp_word == IDX_CNT0 + i) rd_data = cnt[i];
            for (int i = 0; i < N_COUNTERS; i++)
                if (dp_word == IDX_SEL0 + i/4) rd_data[8*(i%4) +: 8] = ev_sel[i];
`ifdef PMU_QUOTA_EN
            if (dp_word == IDX_QMASK)  rd_data = REG_WIDTH'(quota_mask);
            if (dp_word == IDX_QLIMIT) rd_data = quota_limit;
`endif
        end
    end

    assign hrdata_o = rd_data;

endmodule

// File: tb/tb_pmu_ahb_lite.sv
// tb_pmu_ahb_lite: directed self-checking bench for pmu_ahb_lite with hand-computed expectations;
// quota expectations follow whether PMU_QUOTA_EN is defined for the build.
`timescale 1ns/1ps
module tb_pmu_ahb_lite;

    localparam logic [31:0] BASE = 32'h80100000;
`ifdef PMU_QUOTA_EN
    localparam bit QUOTA_ON = 1'b1;
`else
    localparam bit QUOTA_ON = 1'b0;
`endif

    logic         clk_i = 1'b0;
    logic         rstn_i;
    logic         hsel_i;
    logic         hreadyi_i;
    logic [31:0]  haddr_i;
    logic         hwrite_i;
    logic [1:0]   htrans_i;
    logic [2:0]   hsize_i;
    logic [2:0]   hburst_i;
    logic [3:0]   hprot_i;
    logic         hmastlock_i;
    logic [31:0]  hwdata_i;
    logic         hreadyo_o;
    logic [1:0]   hresp_o;
    logic [31:0]  hrdata_o;
    logic [127:0] events_i;
    logic         intr_overflow_o;
    logic         intr_quota_o;
    logic         intr_MCCU_o;
    logic         intr_RDC_o;
    logic         intr_FT1_o;
    logic         intr_FT2_o;

    int n_checks = 0;
    int n_fail   = 0;

    pmu_ahb_lite dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .hsel_i(hsel_i), .hreadyi_i(hreadyi_i), .haddr_i(haddr_i), .hwrite_i(hwrite_i),
        .htrans_i(htrans_i), .hsize_i(hsize_i), .hburst_i(hburst_i), .hprot_i(hprot_i),
        .hmastlock_i(hmastlock_i), .hwdata_i(hwdata_i),
        .hreadyo_o(hreadyo_o), .hresp_o(hresp_o), .hrdata_o(hrdata_o),
        .events_i(events_i), .intr_overflow_o(intr_overflow_o), .intr_quota_o(intr_quota_o),
        .intr_MCCU_o(intr_MCCU_o), .intr_RDC_o(intr_RDC_o),
        .intr_FT1_o(intr_FT1_o), .intr_FT2_o(intr_FT2_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic bus_idle();
        @(posedge clk_i); #1;
        hsel_i   = 1'b0;
        htrans_i = 2'b00;
        hwrite_i = 1'b0;
    endtask

    // Returns during the data phase; the write lands on the following rising edge.
    task automatic ahb_write(input logic [31:0] addr, input logic [31:0] data);
        @(posedge clk_i); #1;
        hsel_i = 1'b1; htrans_i = 2'b10; haddr_i = addr; hwrite_i = 1'b1;
        @(posedge clk_i); #1;
        hsel_i = 1'b0; htrans_i = 2'b00; hwrite_i = 1'b0; hwdata_i = data;
    endtask

    task automatic ahb_read(input logic [31:0] addr, output logic [31:0] data);
        @(posedge clk_i); #1;
        hsel_i = 1'b1; htrans_i = 2'b10; haddr_i = addr; hwrite_i = 1'b0;
        @(posedge clk_i); #1;
        hsel_i = 1'b0; htrans_i = 2'b00;
        @(negedge clk_i);
        data = hrdata_o;
    endtask

    task automatic rd_check(input string tag, input logic [31:0] ofs, input logic [31:0] exp);
        logic [31:0] d;
        ahb_read(BASE + ofs, d);
        check(tag, d, exp);
    endtask

    task automatic pulse_event(input int ev, input int cycles);
        @(posedge clk_i); #1;
        events_i[ev] = 1'b1;
        repeat (cycles) @(posedge clk_i);
        #1 events_i[ev] = 1'b0;
    endtask

    initial begin
        logic [31:0] r1;
        logic [31:0] r2;
        int          bad;

        rstn_i = 1'b0; hsel_i = 1'b0; hreadyi_i = 1'b1; haddr_i = '0; hwrite_i = 1'b0;
        htrans_i = 2'b00; hsize_i = 3'b010; hburst_i = '0; hprot_i = '0; hmastlock_i = 1'b0;
        hwdata_i = '0; events_i = '0;

        // Reset state
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_hreadyo", 32'(hreadyo_o), 32'd1);
        check("rst_hresp",   32'(hresp_o), 32'd0);
        check("rst_hrdata",  hrdata_o, 32'd0);
        check("rst_intr_ovf", 32'(intr_overflow_o), 32'd0);
        check("rst_intr_quota", 32'(intr_quota_o), 32'd0);
        check("rst_intr_tied", 32'({intr_MCCU_o, intr_RDC_o, intr_FT1_o, intr_FT2_o}), 32'd0);
        @(negedge clk_i) rstn_i = 1'b1;

        for (int w = 0; w <= 35; w++) rd_check($sformatf("reset_reg_%0d", w), 32'(w * 4), 32'd0);

        // Quota limit and unmapped offsets
        ahb_write(BASE + 32'h88, 32'hCAFECAFE);
        rd_check("quota_limit_rw", 32'h88, QUOTA_ON ? 32'hCAFECAFE : 32'd0);
        ahb_write(BASE + 32'hAC, 32'hDEADBEEF);
        rd_check("unmapped_ac", 32'hAC, 32'd0);

        // Out-of-region accesses are not claimed
        ahb_write(32'h80200004, 32'h00001234);
        rd_check("outside_write_ignored", 32'h04, 32'd0);
        ahb_read(32'h80200004, r1);
        check("outside_read_zero", r1, 32'd0);

        // Event selection and counting: sel0=5, sel1=200 (out of range), sel2=0, sel3=7
        ahb_write(BASE + 32'h6C, 32'h0700C805);
        rd_check("ev_sel_rw", 32'h6C, 32'h0700C805);
        ahb_write(BASE + 32'h00, 32'd1);
        rd_check("main_enable", 32'h00, 32'd1);
        pulse_event(5, 10);
        rd_check("cnt0_ten_events", 32'h04, 32'd10);
        rd_check("cnt1_sel_out_of_range", 32'h08, 32'd0);
        ahb_write(BASE + 32'h00, 32'd0);
        pulse_event(5, 5);
        rd_check("cnt0_frozen", 32'h04, 32'd10);

        // Bus write beats a simultaneous increment
        ahb_write(BASE + 32'h00, 32'd1);
        ahb_write(BASE + 32'h04, 32'd100);
        events_i[5] = 1'b1;
        bus_idle();
        events_i[5] = 1'b0;
        rd_check("cnt0_write_wins", 32'h04, 32'd100);

        // Wrap and overflow interrupt
        ahb_write(BASE + 32'h64, 32'd8);
        ahb_write(BASE + 32'h10, 32'hFFFFFFFE);
        bus_idle();
        pulse_event(7, 1);
        rd_check("cnt3_all_ones", 32'h10, 32'hFFFFFFFF);
        rd_check("ovf_sts_before_wrap", 32'h68, 32'd0);
        pulse_event(7, 1);
        check("intr_ovf_not_yet", 32'(intr_overflow_o), 32'd0);
        @(posedge clk_i); #1;
        check("intr_ovf_set", 32'(intr_overflow_o), 32'd1);
        rd_check("cnt3_wrapped", 32'h10, 32'd0);
        rd_check("ovf_sts_set", 32'h68, 32'd8);
        ahb_write(BASE + 32'h68, 32'd8);
        rd_check("ovf_sts_w1c", 32'h68, 32'd0);
        check("intr_ovf_cleared", 32'(intr_overflow_o), 32'd0);

        // Write at the wrap point suppresses the overflow
        ahb_write(BASE + 32'h10, 32'hFFFFFFFF);
        ahb_write(BASE + 32'h10, 32'd5);
        events_i[7] = 1'b1;
        bus_idle();
        events_i[7] = 1'b0;
        rd_check("cnt3_write_over_wrap", 32'h10, 32'd5);
        rd_check("ovf_sts_no_set_on_write", 32'h68, 32'd0);

        // Hardware set beats a simultaneous write-1-to-clear
        ahb_write(BASE + 32'h10, 32'hFFFFFFFF);
        ahb_write(BASE + 32'h68, 32'd8);
        events_i[7] = 1'b1;
        bus_idle();
        events_i[7] = 1'b0;
        rd_check("ovf_set_beats_w1c", 32'h68, 32'd8);
        rd_check("cnt3_wrap_during_w1c", 32'h10, 32'd0);
        ahb_write(BASE + 32'h68, 32'd8);
        rd_check("ovf_sts_cleared_again", 32'h68, 32'd0);

        // Back-to-back pipelined transfers: write, write, read, read
        @(posedge clk_i); #1;
        hsel_i = 1'b1; htrans_i = 2'b10; hwrite_i = 1'b1; haddr_i = BASE + 32'h08;
        @(posedge clk_i); #1;
        haddr_i = BASE + 32'h0C; hwdata_i = 32'd11;
        @(posedge clk_i); #1;
        haddr_i = BASE + 32'h08; hwrite_i = 1'b0; hwdata_i = 32'd22;
        @(posedge clk_i); #1;
        haddr_i = BASE + 32'h0C;
        @(negedge clk_i) r1 = hrdata_o;
        @(posedge clk_i); #1;
        hsel_i = 1'b0; htrans_i = 2'b00;
        @(negedge clk_i) r2 = hrdata_o;
        check("b2b_read_cnt1", r1, 32'd11);
        check("b2b_read_cnt2", r2, 32'd22);

        // Quota: counters 0 and 3 selected, limit 150
        ahb_write(BASE + 32'h84, 32'd9);
        ahb_write(BASE + 32'h88, 32'd150);
        ahb_write(BASE + 32'h10, 32'd50);
        bus_idle();
        bus_idle();
        check("quota_at_limit", 32'(intr_quota_o), 32'd0);
        rd_check("quota_mask_rw", 32'h84, QUOTA_ON ? 32'd9 : 32'd0);
        ahb_write(BASE + 32'h10, 32'd51);
        bus_idle();
        check("quota_not_yet", 32'(intr_quota_o), 32'd0);
        bus_idle();
        check("quota_over_limit", 32'(intr_quota_o), QUOTA_ON ? 32'd1 : 32'd0);

        // Softreset clears counters and status, keeps configuration
        ahb_write(BASE + 32'h10, 32'hFFFFFFFF);
        bus_idle();
        pulse_event(7, 1);
        ahb_write(BASE + 32'h10, 32'd7);
        rd_check("ovf_sts_before_softreset", 32'h68, 32'd8);
        ahb_write(BASE + 32'h00, 32'd2);
        rd_check("main_after_softreset", 32'h00, 32'd0);
        rd_check("softreset_cnt0", 32'h04, 32'd0);
        rd_check("softreset_cnt1", 32'h08, 32'd0);
        rd_check("softreset_cnt2", 32'h0C, 32'd0);
        rd_check("softreset_cnt3", 32'h10, 32'd0);
        rd_check("softreset_ovf_sts", 32'h68, 32'd0);
        rd_check("softreset_keeps_ien", 32'h64, 32'd8);
        rd_check("softreset_keeps_sel", 32'h6C, 32'h0700C805);
        check("softreset_intr_ovf", 32'(intr_overflow_o), 32'd0);
        check("softreset_intr_quota", 32'(intr_quota_o), 32'd0);
        ahb_write(BASE + 32'h00, 32'd3);
        rd_check("main_enable_with_softreset", 32'h00, 32'd1);

        // Random traffic, in and out of the region
        bad = 0;
        for (int k = 0; k < 10000; k++) begin
            @(posedge clk_i); #1;
            hsel_i    = 1'($urandom_range(0, 1));
            htrans_i  = 2'($urandom_range(0, 3));
            hwrite_i  = 1'($urandom_range(0, 1));
            hreadyi_i = 1'b1;
            haddr_i   = ($urandom_range(0, 1) == 1) ? (BASE | ($urandom & 32'hFFF)) : $urandom;
            hwdata_i  = $urandom;
            @(negedge clk_i);
            if (hreadyo_o !== 1'b1 || hresp_o !== 2'b00) bad++;
        end
        bus_idle();
        check("random_ready_okay_violations", 32'(bad), 32'd0);
        check("random_end_hreadyo", 32'(hreadyo_o), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
